hc_enc_21_16: RTL and testbench
===============================

# hc_enc_21_16

Hamming(21,16) encoder stage that consumes 16-bit words from the LFSR data generator and produces systematic-position Hamming codewords for the channel/error-injection stage downstream. Includes a 2-entry output buffer with valid/ready handshakes on both sides, so downstream back-pressure never corrupts or drops LFSR words. Also maintains a wrap-around count of delivered codewords for the bench and status logic.

## Interface
- DEPTH, 2, output buffer entries; fixed at 2, not to be overridden.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- data_in  in  16  LFSR word to encode.
- in_valid  in  1  data_in is valid this cycle.
- in_ready  out  1  block can accept a word this cycle.
- code_out  out  22  codeword; bit i-1 = Hamming position i (1..21); bit 21 = overall parity.
- out_valid  out  1  code_out holds a valid codeword.
- out_ready  in  1  downstream accepts code_out this cycle.
- word_cnt  out  16  codewords delivered since reset, wraps 0xFFFF -> 0x0000.

## Operation
- Accept (push) when in_valid && in_ready; deliver (pop) when out_valid && out_ready.
- Data placement: d0..d15 fill positions 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21 in ascending order.
- Parity at positions 1,2,4,8,16: p(2^k) = XOR of all data positions whose index has bit k set (even parity).
- Encoding is combinational on data_in; the encoded 22-bit value is written into the buffer on push.
- Buffer: 2-entry FIFO, write pointer, read pointer (1 bit each), occupancy count 0..2.
- in_ready = (occupancy != 2); combinational from state only, never from out_ready.
- out_valid = (occupancy != 0); code_out = entry at read pointer (don't-care but stable when empty).
- Simultaneous push and pop with occupancy 1: occupancy stays 1, pointers both advance, order preserved.
- Full (2): no push, even if a pop occurs in the same cycle; in_valid held by upstream.
- Empty (0): out_valid low; a push makes out_valid high the next cycle.
- word_cnt increments by 1 on every pop; modulo 2^16.
- Once out_valid is high, code_out stays constant until popped.
- Reset mid-operation: buffered words discarded, no partial output.

## Timing
- Reset values: in_ready=1, out_valid=0, code_out=0, word_cnt=0, occupancy=0, pointers=0.
- During rst_n=0: in_valid ignored, no push/pop, in_ready=0 is NOT asserted (reports reset value 1 only after the reset edge; during reset cycles output is 1 but pushes are ignored).
- Latency: word pushed at edge N is visible on code_out with out_valid=1 from edge N until popped; 1 cycle input-to-output.
- Throughput: 1 word/cycle sustained when out_ready held high.
- Back-pressure: with out_ready low, two words are absorbed; in_ready drops the cycle after the second push.
- word_cnt updates on the same edge as the pop.

## Configuration
- HC_SECDED_EN defined: code_out[21] = XOR of code_out[20:0] (overall parity, SECDED 22-bit code).
- HC_SECDED_EN undefined: code_out[21] tied to 0; plain SEC Hamming(21,16); all other behaviour identical.

## Test plan
- Reset then push 0x0000, out_ready=1 -> code_out=0x000000, out_valid 1 cycle, word_cnt=1.
- Push 0x0001 -> code_out=0x200007 with HC_SECDED_EN, 0x000007 without.
- Push 0xFFFF -> 0x1FFFFE; push 0x8000 -> 0x108009 (both macro settings).
- out_ready=0, push 3 LFSR words back-to-back -> in_ready low after 2nd, 3rd held; release out_ready -> 3 codewords in order, no loss/duplication.
- Stream 65537 words with out_ready=1 -> word_cnt wraps to 0x0001; every codeword matches reference model.
- Assert rst_n=0 with 2 entries buffered -> next cycle out_valid=0, word_cnt=0, in_ready=1; buffered words never appear.

Source files
------------

// File: rtl/hc_enc_21_16.sv
// Hamming(21,16) encoder with a 2-entry output FIFO and a delivered-word counter.
// Define HC_SECDED_EN to drive code_out[21] with overall parity (22-bit SECDED); otherwise bit 21 is 0.
module hc_enc_21_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [21:0] code_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] word_cnt
);

  // Buffer depth is fixed; pointers and occupancy are sized for exactly two entries.
  localparam int DEPTH = 2;

  // Parity coverage masks over code bits 20:0 (bit i-1 = position i).
  localparam logic [20:0] P1_MASK  = 21'h155555;
  localparam logic [20:0] P2_MASK  = 21'h066666;
  localparam logic [20:0] P4_MASK  = 21'h187878;
  localparam logic [20:0] P8_MASK  = 21'h007F80;
  localparam logic [20:0] P16_MASK = 21'h1F8000;

  function automatic logic [21:0] hc_encode(input logic [15:0] d);
    logic [20:0] dv;
    logic [20:0] c;
    logic        ov;
    dv        = '0;
    dv[2]     = d[0];
    dv[6:4]   = d[3:1];
    dv[14:8]  = d[10:4];
    dv[20:16] = d[15:11];
    c         = dv;
    c[0]      = ^(dv & P1_MASK);
    c[1]      = ^(dv & P2_MASK);
    c[3]      = ^(dv & P4_MASK);
    c[7]      = ^(dv & P8_MASK);
    c[15]     = ^(dv & P16_MASK);
`ifdef HC_SECDED_EN
    ov = ^c;
`else
    ov = 1'b0;
`endif
    return {ov, c};
  endfunction

  // Handshake: a word transfers on a rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready depends only on occupancy.
  logic [21:0] mem [DEPTH];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [15:0] word_cnt_q;
  logic [21:0] enc;
  logic        push;
  logic        pop;

  always_comb begin
    enc       = hc_encode(data_in);
    in_ready  = (count != 2'd2);
    out_valid = (count != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    code_out  = mem[rd_ptr];
    word_cnt  = word_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      word_cnt_q <= 16'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_enc_21_16.sv
// Bench for hc_enc_21_16: known-answer table, back-pressure, counter wrap, random traffic, mid-run reset.
module tb_hc_enc_21_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] code_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_cnt;

  int checks;
  int errors;
  logic [21:0] exp_q[$];

  typedef struct {
    logic [15:0] d;
    logic [21:0] exp;
  } vec_t;

  hc_enc_21_16 dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .code_out(code_out), .out_valid(out_valid),
    .out_ready(out_ready), .word_cnt(word_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [21:0] ref_enc(input logic [15:0] d);
    logic [21:0] c;
    int          j;
    logic        par;
    c = '0;
    j = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 21; p++)
        if (((p >> k) & 1) == 1) par = par ^ c[p-1];
      c[(1 << k) - 1] = par;
    end
`ifdef HC_SECDED_EN
    c[21] = ^c[20:0];
`endif
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard (runs once per falling edge) ----------------
  task automatic sb_step();
    logic [21:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("occ_in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      check("occ_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0)
        check("sb_head", {10'd0, code_out}, {10'd0, exp_q[0]});
      if (out_valid && out_ready && exp_q.size() != 0)
        e = exp_q.pop_front();
      if (in_valid && in_ready)
        exp_q.push_back(ref_enc(data_in));
    end
  endtask

  task automatic half();
    @(negedge clk);
    sb_step();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    rise();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      half();
      if (in_ready) done = 1'b1;
      rise();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) cyc();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs[4];
    logic [15:0] w0, w1, w2;
    logic [15:0] cnt0;
    int          stalls;

    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    data_in  = '0;

    vecs[0] = '{16'h0000, 22'h000000};
`ifdef HC_SECDED_EN
    vecs[1] = '{16'h0001, 22'h200007};
`else
    vecs[1] = '{16'h0001, 22'h000007};
`endif
    vecs[2] = '{16'hFFFF, 22'h1FFFFE};
    vecs[3] = '{16'h8000, 22'h108009};

    do_reset();
    half();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_code_out", {10'd0, code_out}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    rise();

    // Known-answer table: one word at a time, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].d);
      half();
      check("kat_valid", {31'd0, out_valid}, 32'd1);
      check("kat_code", {10'd0, code_out}, {10'd0, vecs[i].exp});
      rise();
      half();
      check("kat_valid_drop", {31'd0, out_valid}, 32'd0);
      check("kat_word_cnt", {16'd0, word_cnt}, i + 1);
      rise();
    end

    // Back-pressure: two words absorbed, third held until release.
    out_ready = 1'b0;
    cnt0 = word_cnt;
    w0 = 16'($urandom_range(0, 65535));
    w1 = 16'($urandom_range(0, 65535));
    w2 = 16'($urandom_range(0, 65535));
    send(w0);
    send(w1);
    in_valid = 1'b1;
    data_in  = w2;
    for (int t = 0; t < 3; t++) begin
      half();
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_hold_code", {10'd0, code_out}, {10'd0, ref_enc(w0)});
      rise();
    end
    out_ready = 1'b1;
    send(w2);
    drain();
    check("bp_word_cnt", {16'd0, word_cnt}, {16'd0, cnt0 + 16'd3});

    // Random traffic with random back-pressure.
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      data_in   = 16'($urandom_range(0, 65535));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Mid-run reset with both entries occupied.
    out_ready = 1'b0;
    send(16'h1234);
    send(16'hBEEF);
    half();
    check("mr_full", {31'd0, in_ready}, 32'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 16'hA5A5;
    rise();
    half();
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    check("mr_code_out", {10'd0, code_out}, 32'd0);
    rise();
    cyc();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    check("mr_no_stale_cnt", {16'd0, word_cnt}, 32'd0);

    // Full-rate stream of 65537 words: counter wraps to 1, never stalls.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    stalls    = 0;
    for (int n = 0; n < 65537; n++) begin
      data_in = 16'($urandom_range(0, 65535));
      half();
      if (!in_ready) stalls++;
      rise();
    end
    in_valid = 1'b0;
    drain();
    check("wrap_word_cnt", {16'd0, word_cnt}, 32'd1);
    check("stream_stalls", stalls, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
